// File: rtl/multicycle_ctrl_pkg.sv
// Shared types, opcodes and mux encodings for the multicycle controller.
// Imported by the interface, decoder and top level.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JAL    = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_R31 = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] reg_dst;
    logic [1:0] memto_reg;
  } ctrl_t;

  // First state after DECODE for a given opcode; anything unknown traps.
  function automatic state_t op_target(input logic [5:0] op);
    state_t t;
    t = S_TRAP;
    unique case (1'b1)
      (op == OP_LW),
      (op == OP_SW):   t = S_MEMADR;
      (op == OP_R):    t = S_EXEC;
      (op == OP_BEQ),
      (op == OP_BNE):  t = S_BRANCH;
      (op == OP_J):    t = S_JUMP;
      (op == OP_JAL):  t = S_JAL;
      (op == OP_ADDI): t = S_ADDIEX;
      default:         t = S_TRAP;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Opcode/memory-ready inputs and datapath control bundle.
// master = controller, slave = datapath.
interface multicycle_ctrl_if;
  import multicycle_pkg::*;

  logic [5:0] Op;
  logic       mem_ready;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       BranchNe;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] PCSource;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcB;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;

  modport master (
    input  Op, mem_ready,
    output PCWrite, PCWriteCond, BranchNe,
    output IorD, MemRead, MemWrite,
    output IRWrite, RegWrite, ALUSrcA,
    output PCSource, ALUOp, ALUSrcB,
    output RegDst, MemtoReg
  );

  modport slave (
    output Op, mem_ready,
    input  PCWrite, PCWriteCond, BranchNe,
    input  IorD, MemRead, MemWrite,
    input  IRWrite, RegWrite, ALUSrcA,
    input  PCSource, ALUOp, ALUSrcB,
    input  RegDst, MemtoReg
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational control-output decode from the registered state.
// Only the FETCH IRWrite/PCWrite pair and MEMWR retire see mem_ready.
module multicycle_ctrl_decode
  import multicycle_pkg::*;
(
  input  state_t state,
  input  logic   is_bne,
  input  logic   mem_ready,
  output ctrl_t  ctrl,
  output logic   illegal_op,
  output logic   instr_done
);

  always_comb begin
    ctrl       = '0;
    illegal_op = 1'b0;
    instr_done = 1'b0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_SHIMM;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.memto_reg = M2R_MEM;
        ctrl.reg_dst   = REGDST_RT;
        instr_done     = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
        instr_done     = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = REGDST_RD;
        instr_done     = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_OUT;
        ctrl.branch_ne     = is_bne;
        instr_done         = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        instr_done     = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = REGDST_RT;
        instr_done     = 1'b1;
      end
      S_JAL: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = REGDST_R31;
        ctrl.memto_reg = M2R_PC;
        instr_done     = 1'b1;
      end
      S_TRAP: begin
        illegal_op = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath controller: state register, sequencing,
// latched branch/store flags and retired-instruction counter.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int MEM_WAIT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus,
  output logic [3:0]          state,
  output logic                illegal_op,
  output logic                instr_done,
  output logic [CNT_W-1:0]    retired
);

  state_t state_q;
  state_t state_d;
  logic   is_bne;
  logic   is_sw;
  logic   ready;
  ctrl_t  ctrl;

  assign ready = (MEM_WAIT == 0) ? 1'b1 : bus.mem_ready;
  assign state = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (ready) state_d = S_DECODE;
      S_DECODE: state_d = op_target(bus.Op);
      S_MEMADR: state_d = is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (ready) state_d = S_MEMWB;
      S_MEMWR:  if (ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_TRAP:   state_d = S_TRAP;
      S_MEMWB,
      S_RWB,
      S_BRANCH,
      S_JUMP,
      S_ADDIWB,
      S_JAL:    state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Opcode is captured once in DECODE so later IR changes cannot leak in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      is_bne  <= 1'b0;
      is_sw   <= 1'b0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        is_bne <= (bus.Op == OP_BNE);
        is_sw  <= (bus.Op == OP_SW);
      end
      if (instr_done) retired <= retired + CNT_W'(1);
    end
  end

  multicycle_ctrl_decode u_decode (
    .state      (state_q),
    .is_bne     (is_bne),
    .mem_ready  (ready),
    .ctrl       (ctrl),
    .illegal_op (illegal_op),
    .instr_done (instr_done)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.BranchNe    = ctrl.branch_ne;
  assign bus.IorD        = ctrl.ior_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.MemtoReg    = ctrl.memto_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two instances (waits on / 2-bit counter
// without waits) checked every cycle against a path-based model.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       rdy;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_ctrl_if bus0();
  multicycle_ctrl_if bus1();

  assign bus0.Op = op;
  assign bus0.mem_ready = rdy;
  assign bus1.Op = op;
  assign bus1.mem_ready = rdy;

  logic [3:0]  st0, st1;
  logic        ill0, ill1, done0, done1;
  logic [31:0] ret0;
  logic [1:0]  ret1;

  multicycle_ctrl #(.CNT_W(32), .MEM_WAIT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .state(st0),
    .illegal_op(ill0), .instr_done(done0), .retired(ret0)
  );

  multicycle_ctrl #(.CNT_W(2), .MEM_WAIT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .state(st1),
    .illegal_op(ill1), .instr_done(done1), .retired(ret1)
  );

  logic [18:0] act0, act1;
  assign act0 = {bus0.PCWrite, bus0.PCWriteCond, bus0.BranchNe,
                 bus0.IorD, bus0.MemRead, bus0.MemWrite,
                 bus0.IRWrite, bus0.RegWrite, bus0.ALUSrcA,
                 bus0.PCSource, bus0.ALUOp, bus0.ALUSrcB,
                 bus0.RegDst, bus0.MemtoReg};
  assign act1 = {bus1.PCWrite, bus1.PCWriteCond, bus1.BranchNe,
                 bus1.IorD, bus1.MemRead, bus1.MemWrite,
                 bus1.IRWrite, bus1.RegWrite, bus1.ALUSrcA,
                 bus1.PCSource, bus1.ALUOp, bus1.ALUSrcB,
                 bus1.RegDst, bus1.MemtoReg};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: an instruction is FETCH, DECODE, then an opcode-specific path.
  int          m_st[2];
  int          m_pos[2];
  logic        m_bne[2];
  logic [5:0]  m_op[2];
  logic [31:0] m_ret[2];
  logic        armed = 1'b0;

  function automatic int route(input logic [5:0] o, input int k);
    int r[$];
    case (o)
      6'b100011: r = '{2, 3, 4};
      6'b101011: r = '{2, 5};
      6'b000000: r = '{6, 7};
      6'b000100: r = '{8};
      6'b000101: r = '{8};
      6'b000010: r = '{9};
      6'b000011: r = '{12};
      6'b001000: r = '{10, 11};
      default:   r = '{13};
    endcase
    if (k < r.size()) return r[k];
    return -1;
  endfunction

  function automatic logic is_wait(input int s);
    return (s == 0) || (s == 3) || (s == 5);
  endfunction

  function automatic logic exp_done(input int i, input logic rd);
    int s;
    s = m_st[i];
    if (s == 0 || s == 1 || s == 13) return 1'b0;
    if (is_wait(s) && !rd) return 1'b0;
    return route(m_op[i], m_pos[i] + 1) < 0;
  endfunction

  function automatic logic [18:0] exp_ctrl(input int s, input logic bne,
                                           input logic rd);
    logic pcw, pcwc, bn, iord, mr, mw, irw, rw, sa;
    logic [1:0] pcs, aop, sb, rdst, m2r;
    {pcw, pcwc, bn, iord, mr, mw, irw, rw, sa} = '0;
    {pcs, aop, sb, rdst, m2r} = '0;
    case (s)
      0:  begin mr = 1; sb = 2'b01; irw = rd; pcw = rd; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 2'b01; end
      5:  begin mw = 1; iord = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 2'b01; end
      8:  begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; bn = bne; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      12: begin pcw = 1; pcs = 2'b10; rw = 1; rdst = 2'b10; m2r = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, bn, iord, mr, mw, irw, rw, sa,
            pcs, aop, sb, rdst, m2r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        logic rd;
        rd = (i == 1) ? 1'b1 : rdy;
        if (!rst_n) begin
          m_st[i] = 0; m_pos[i] = 0; m_bne[i] = 1'b0;
          m_op[i] = '0; m_ret[i] = '0;
        end else begin
          if (exp_done(i, rd)) m_ret[i] = m_ret[i] + 1;
          if (m_st[i] == 13 || (is_wait(m_st[i]) && !rd)) begin
          end else if (m_st[i] == 0) begin
            m_st[i] = 1;
          end else if (m_st[i] == 1) begin
            m_op[i]  = op;
            m_bne[i] = (op == 6'b000101);
            m_pos[i] = 0;
            m_st[i]  = route(op, 0);
          end else begin
            m_pos[i]++;
            m_st[i] = (route(m_op[i], m_pos[i]) < 0) ? 0
                      : route(m_op[i], m_pos[i]);
          end
        end
      end
      if (!rst_n) armed = 1'b1;
    end
  end

  task automatic cmp(input int i, input logic [3:0] s, input logic [18:0] c,
                     input logic il, input logic d, input logic [31:0] r,
                     input logic [31:0] mask);
    logic rd;
    rd = (i == 1) ? 1'b1 : rdy;
    chk($sformatf("u%0d_state", i), 32'(s), m_st[i]);
    chk($sformatf("u%0d_ctrl", i), 32'(c), 32'(exp_ctrl(m_st[i], m_bne[i], rd)));
    chk($sformatf("u%0d_illegal", i), 32'(il), 32'(m_st[i] == 13));
    chk($sformatf("u%0d_done", i), 32'(d), 32'(exp_done(i, rd)));
    chk($sformatf("u%0d_retired", i), r, m_ret[i] & mask);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (armed) begin
        cmp(0, st0, act0, ill0, done0, ret0, 32'hffff_ffff);
        cmp(1, st1, act1, ill1, done1, {30'd0, ret1}, 32'h3);
      end
    end
  end

  task automatic step(input logic r, input logic [5:0] o, input logic m);
    @(negedge clk);
    rst_n = r;
    op    = o;
    rdy   = m;
    #3;
  endtask

  int   lw_st[8] = '{0, 0, 0, 1, 2, 3, 3, 4};
  logic lw_rd[8] = '{0, 0, 1, 1, 1, 0, 1, 1};
  int   wrap_exp[5] = '{1, 2, 3, 0, 1};
  logic [5:0] legal[8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                           6'b000101, 6'b000010, 6'b000011, 6'b001000};

  initial begin
    int irw_cnt;
    logic [31:0] ret_hold;
    rst_n = 1'b1;
    op    = 6'h00;
    rdy   = 1'b1;

    step(0, 6'h00, 1);

    step(1, 6'h00, 0);
    chk("reset_state", 32'(st0), 0);
    chk("reset_retired", ret0, 0);
    chk("reset_memread", 32'(bus0.MemRead), 1);
    chk("reset_srcb", 32'(bus0.ALUSrcB), 1);
    chk("reset_irwrite", 32'(bus0.IRWrite), 0);
    chk("reset_pcwrite", 32'(bus0.PCWrite), 0);

    step(1, 6'h00, 1);
    chk("r_fetch", 32'(st0), 0);
    chk("r_irwrite", 32'(bus0.IRWrite), 1);
    step(1, 6'h00, 1);
    chk("r_decode", 32'(st0), 1);
    step(1, 6'h00, 1);
    chk("r_exec", 32'(st0), 6);
    chk("r_exec_regwrite", 32'(bus0.RegWrite), 0);
    step(1, 6'h00, 1);
    chk("r_rwb", 32'(st0), 7);
    chk("r_rwb_regwrite", 32'(bus0.RegWrite), 1);
    chk("r_rwb_regdst", 32'(bus0.RegDst), 1);
    chk("model_r_rwb", 32'(m_st[0]), 7);

    irw_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step(1, 6'b100011, lw_rd[k]);
      chk($sformatf("lw_state%0d", k), 32'(st0), 32'(lw_st[k]));
      if (k == 0) chk("r_retired", ret0, 1);
      if (bus0.IRWrite) irw_cnt++;
      if (k == 7) chk("lw_memtoreg", 32'(bus0.MemtoReg), 1);
    end
    chk("lw_irwrite_once", 32'(irw_cnt), 1);

    step(1, 6'b000101, 1);
    chk("lw_len8", 32'(st0), 0);
    step(1, 6'b000101, 1);
    chk("bne_decode", 32'(st0), 1);
    step(1, 6'b000000, 1);
    chk("bne_branch", 32'(st0), 8);
    chk("bne_branchne", 32'(bus0.BranchNe), 1);
    chk("bne_pcwc", 32'(bus0.PCWriteCond), 1);

    step(1, 6'b000011, 1);
    chk("bne_len3", 32'(st0), 0);
    chk("bne_off", 32'(bus0.BranchNe), 0);
    chk("pcwc_off", 32'(bus0.PCWriteCond), 0);
    step(1, 6'b000011, 1);
    step(1, 6'b000000, 1);
    chk("jal_state", 32'(st0), 12);
    chk("jal_pcwrite", 32'(bus0.PCWrite), 1);
    chk("jal_regwrite", 32'(bus0.RegWrite), 1);
    chk("jal_regdst", 32'(bus0.RegDst), 2);
    chk("jal_memtoreg", 32'(bus0.MemtoReg), 2);

    step(1, 6'b111111, 1);
    chk("pre_trap_retired", ret0, 4);
    ret_hold = ret0;
    step(1, 6'b111111, 1);
    for (int k = 0; k < 10; k++) begin
      step(1, 6'($urandom), 1'($urandom));
      chk("trap_state", 32'(st0), 13);
      chk("trap_illegal", 32'(ill0), 1);
      chk("trap_retired", ret0, ret_hold);
    end
    step(0, 6'b000010, 1);
    step(1, 6'b000010, 1);
    chk("trap_exit_state", 32'(st0), 0);
    chk("trap_exit_retired", ret0, 0);
    chk("trap_exit_illegal", 32'(ill0), 0);

    for (int n = 0; n < 5; n++) begin
      if (n > 0) step(1, 6'b000010, 1);
      step(1, 6'b000010, 1);
      step(1, 6'b000010, 1);
      chk("j_state", 32'(st1), 9);
      @(posedge clk);
      #1;
      chk($sformatf("wrap%0d", n), 32'(ret1), 32'(wrap_exp[n]));
    end

    for (int c = 0; c < 3000; c++) begin
      logic       r;
      logic [5:0] o;
      r = ($urandom_range(0, 99) >= 2);
      o = ($urandom_range(0, 19) == 0) ? 6'($urandom)
          : legal[$urandom_range(0, 7)];
      step(r, o, ($urandom_range(0, 3) != 0));
    end

    step(1, 6'h00, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
